// File: rtl/pipe_defs.sv
// Shared pipeline definitions: hazard field widths, MD unit timing defaults, MD FSM encodings.
package pipe_defs;
  localparam int TW          = 2;
  localparam logic [TW-1:0] TUSE_NONE = 2'd3;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;
endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy window: goes busy on the edge after a start and stays busy for exactly N cycles.
// Start requests arriving while busy are dropped; the controller's stall keeps them from happening.
import pipe_defs::*;

module md_busy_timer #(
  parameter int MULT_CYCLES = pipe_defs::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_defs::DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic div,
  output logic busy
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MD_IDLE: begin
        if (go) begin
          state_next = MD_BUSY;
          cnt_next   = div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_next = MD_IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
  end

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(go && state == MD_BUSY));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: zero-latency RAW and MD-busy stalls for PC, F/D and D/E; M-stage exceptions flush all.
// Shadow copies of the E/M destination and Tnew track what the D/E and E/M registers hold.
import pipe_defs::*;

module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = pipe_defs::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_defs::DIV_CYCLES,
  parameter int TW          = pipe_defs::TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_D,
  input  logic [4:0]    rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic [4:0]    a3_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          md_use_D,
  input  logic          md_start_E,
  input  logic          md_div_E,
  input  logic          exc_M,
  output logic          stall_F,
  output logic          stall_D,
  output logic          clr_E,
  output logic          flush_all,
  output logic          md_go_E,
  output logic          md_busy
);
  logic [4:0]    a3_Es, a3_Ms;
  logic [TW-1:0] tnew_Es, tnew_Ms;
  logic          raw_rs, raw_rt, md_stall, hold;

  // Register $0 never creates a dependency, even if a shadow slot holds 0.
  assign raw_rs = (rs_D != 5'd0) &&
                  (((rs_D == a3_Es) && (tnew_Es > tuse_rs_D)) ||
                   ((rs_D == a3_Ms) && (tnew_Ms > tuse_rs_D)));
  assign raw_rt = (rt_D != 5'd0) &&
                  (((rt_D == a3_Es) && (tnew_Es > tuse_rt_D)) ||
                   ((rt_D == a3_Ms) && (tnew_Ms > tuse_rt_D)));

  assign md_stall  = md_use_D & (md_busy | md_start_E);
  assign hold      = (raw_rs | raw_rt | md_stall) & ~exc_M;
  assign stall_F   = hold;
  assign stall_D   = hold;
  assign clr_E     = hold;
  assign flush_all = exc_M;
  assign md_go_E   = md_start_E & ~exc_M;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_Es   <= '0;
      tnew_Es <= '0;
      a3_Ms   <= '0;
      tnew_Ms <= '0;
    end else begin
      if (clr_E | flush_all) begin
        a3_Es   <= '0;
        tnew_Es <= '0;
      end else begin
        a3_Es   <= a3_D;
        tnew_Es <= tnew_D;
      end
      if (flush_all) begin
        a3_Ms   <= '0;
        tnew_Ms <= '0;
      end else begin
        a3_Ms   <= a3_Es;
        tnew_Ms <= (tnew_Es == '0) ? '0 : tnew_Es - TW'(1);
      end
    end
  end

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk  (clk),
    .reset(reset),
    .go   (md_go_E),
    .div  (md_div_E),
    .busy (md_busy)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       md_use_D, md_start_E, md_div_E, exc_M;
  logic       stall_F, stall_D, clr_E, flush_all, md_go_E, md_busy;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .tnew_D(tnew_D), .md_use_D(md_use_D),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .exc_M(exc_M),
    .stall_F(stall_F), .stall_D(stall_D), .clr_E(clr_E),
    .flush_all(flush_all), .md_go_E(md_go_E), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tn, input logic mdu);
    rs_D = rs; tuse_rs_D = tu_rs; rt_D = rt; tuse_rt_D = tu_rt;
    a3_D = a3; tnew_D = tn; md_use_D = mdu;
    #1;
  endtask

  // D holds a no-op; two edges drain both shadow slots.
  task automatic drain();
    set_d(0, 3, 0, 3, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    md_start_E = 0; md_div_E = 0; exc_M = 0;
    set_d(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall_F", stall_F, 0);
    chk("rst_stall_D", stall_D, 0);
    chk("rst_clr_E", clr_E, 0);
    chk("rst_flush", flush_all, 0);
    chk("rst_go", md_go_E, 0);
    chk("rst_busy", md_busy, 0);
    tick();
    reset = 1'b0;
    tick();

    // lw $1 enters E, then addu reading $1 at tuse=1
    set_d(0, 3, 0, 3, 1, 2, 0);
    tick();
    set_d(1, 1, 0, 3, 3, 1, 0);
    chk("lw_use_stall_F", stall_F, 1);
    chk("lw_use_stall_D", stall_D, 1);
    chk("lw_use_clr_E", clr_E, 1);
    tick();
    #1;
    chk("lw_in_M_no_stall", stall_D, 0);
    drain();

    // addu $2 in E, beq $2 in D (tuse 0), via rs then via rt
    set_d(0, 3, 0, 3, 2, 1, 0);
    tick();
    set_d(2, 0, 0, 0, 0, 0, 0);
    chk("beq_rs_stall", stall_D, 1);
    set_d(0, 0, 2, 0, 0, 0, 0);
    chk("beq_rt_stall", stall_D, 1);
    tick();
    #1;
    chk("beq_after_1", stall_D, 0);
    drain();
    set_d(0, 3, 0, 3, 0, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0);
    chk("beq_r0_no_stall", stall_D, 0);
    drain();

    // mult start in E with mflo in D: start cycle plus 5 busy cycles
    set_d(0, 3, 0, 3, 0, 0, 1);
    md_div_E = 0; md_start_E = 1;
    #1;
    chk("mult_go", md_go_E, 1);
    n = 0;
    while (stall_D && n < 40) begin
      n++;
      tick();
      md_start_E = 0;
      #1;
    end
    chk("mult_stall_cycles", n, 6);
    chk("mult_busy_done", md_busy, 0);

    md_div_E = 1; md_start_E = 1;
    #1;
    n = 0;
    while (stall_D && n < 40) begin
      n++;
      tick();
      md_start_E = 0;
      #1;
    end
    chk("div_stall_cycles", n, 11);
    md_div_E = 0;
    drain();

    // exception with a RAW hazard pending: flush wins
    set_d(0, 3, 0, 3, 5, 2, 0);
    tick();
    set_d(5, 0, 0, 3, 5, 2, 0);
    exc_M = 1;
    #1;
    chk("exc_flush", flush_all, 1);
    chk("exc_stall_F", stall_F, 0);
    chk("exc_stall_D", stall_D, 0);
    chk("exc_clr_E", clr_E, 0);
    tick();
    exc_M = 0;
    set_d(5, 0, 0, 3, 0, 0, 0);
    chk("exc_shadows_zero", stall_D, 0);
    drain();

    // exception in the same cycle as a divide start
    md_div_E = 1; md_start_E = 1; exc_M = 1;
    #1;
    chk("exc_start_go", md_go_E, 0);
    tick();
    md_start_E = 0; exc_M = 0; md_div_E = 0;
    #1;
    chk("exc_start_busy", md_busy, 0);
    tick();
    chk("exc_start_busy2", md_busy, 0);

    // asynchronous reset in the middle of a divide
    set_d(0, 3, 0, 3, 7, 2, 0);
    md_div_E = 1; md_start_E = 1;
    tick();
    md_start_E = 0; md_div_E = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("div_busy_cnt4", md_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", md_busy, 0);
    set_d(7, 0, 0, 3, 0, 0, 0);
    chk("async_rst_shadow", stall_D, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_stall", stall_D, 0);
    tick();
    chk("post_rst_busy", md_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
